// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, LSB first, one bit per clock.
// Define SERIAL_ADDSUB_PAR_OUT_EN to add the parallel `result` output.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             stall,
   output logic             busy,
   output logic             sout,
   output logic             sout_valid,
   output logic             done,
   output logic             cout,
   output logic             overflow
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
   ,
   output logic [WIDTH-1:0] result
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] sh_a, sh_a_n;
   logic [WIDTH-1:0] sh_b, sh_b_n;
   logic             carry, carry_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             busy_n;
   logic             sout_n;
   logic             sout_valid_n;
   logic             done_n;
   logic             cout_n;
   logic             overflow_n;

   logic             s;
   logic             c_out;
   logic             last;

`ifdef SERIAL_ADDSUB_PAR_OUT_EN
   logic [WIDTH-1:0] col, col_n;
   logic [WIDTH-1:0] result_n;
`endif

   // Single full adder on the operand LSBs and the carry flop.
   always_comb begin
      s     = sh_a[0] ^ sh_b[0] ^ carry;
      c_out = (sh_a[0] & sh_b[0]) |
              (sh_a[0] & carry) |
              (sh_b[0] & carry);
      last  = (cnt == CW'(WIDTH - 1));
   end

   // Next-state and output logic.
   always_comb begin
      state_n      = state;
      sh_a_n       = sh_a;
      sh_b_n       = sh_b;
      carry_n      = carry;
      cnt_n        = cnt;
      busy_n       = busy;
      sout_n       = sout;
      sout_valid_n = 1'b0;
      done_n       = 1'b0;
      cout_n       = cout;
      overflow_n   = overflow;
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
      col_n        = col;
      result_n     = result;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               sh_a_n  = a;
               sh_b_n  = sub ? ~b : b;
               carry_n = sub;
               cnt_n   = '0;
               busy_n  = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            if (!stall) begin
               sout_n       = s;
               sout_valid_n = 1'b1;
               carry_n      = c_out;
               sh_a_n       = {1'b0, sh_a[WIDTH-1:1]};
               sh_b_n       = {1'b0, sh_b[WIDTH-1:1]};
               cnt_n        = cnt + 1'b1;
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
               col_n        = {s, col[WIDTH-1:1]};
`endif
               if (last) begin
                  // carry still holds the carry into the MSB here
                  done_n     = 1'b1;
                  cout_n     = c_out;
                  overflow_n = carry ^ c_out;
                  busy_n     = 1'b0;
                  cnt_n      = '0;
                  state_n    = IDLE;
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
                  result_n   = {s, col[WIDTH-1:1]};
`endif
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State and datapath registers; synchronous reset clears everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         sh_a       <= '0;
         sh_b       <= '0;
         carry      <= 1'b0;
         cnt        <= '0;
         busy       <= 1'b0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         done       <= 1'b0;
         cout       <= 1'b0;
         overflow   <= 1'b0;
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
         col        <= '0;
         result     <= '0;
`endif
      end else begin
         state      <= state_n;
         sh_a       <= sh_a_n;
         sh_b       <= sh_b_n;
         carry      <= carry_n;
         cnt        <= cnt_n;
         busy       <= busy_n;
         sout       <= sout_n;
         sout_valid <= sout_valid_n;
         done       <= done_n;
         cout       <= cout_n;
         overflow   <= overflow_n;
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
         col        <= col_n;
         result     <= result_n;
`endif
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for serial_addsub (WIDTH=8).
// Stimulus pushes expected results; a negedge monitor checks on done.
module tb_serial_addsub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         stall = 1'b0;
   logic         busy, sout, sout_valid, done, cout, overflow;
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
   logic [W-1:0] result;
`endif

   serial_addsub #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .sub        (sub),
      .a          (a),
      .b          (b),
      .stall      (stall),
      .busy       (busy),
      .sout       (sout),
      .sout_valid (sout_valid),
      .done       (done),
      .cout       (cout),
      .overflow   (overflow)
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
      ,
      .result     (result)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] r;
      bit           c;
      bit           v;
      int           lat;
      int           st;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic exp_t model(input int ua, input int ub, input bit s,
                                  input int nst);
      exp_t e;
      int   r, sa, sbv, sr;
      r   = s ? ua - ub : ua + ub;
      sa  = (ua >= 2**(W-1)) ? ua - 2**W : ua;
      sbv = (ub >= 2**(W-1)) ? ub - 2**W : ub;
      sr  = s ? sa - sbv : sa + sbv;
      e.r   = W'(r & (2**W - 1));
      e.c   = s ? (ua >= ub) : (r >= 2**W);
      e.v   = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1)));
      e.lat = W + nst;
      e.st  = 0;
      return e;
   endfunction

   // Monitor: assemble serial bits and compare with the scoreboard on done.
   logic [W-1:0] bits;
   int           nb = 0;
   always @(negedge clk) begin
      if (reset) begin
         nb = 0;
         bits = '0;
      end else begin
         if (sout_valid) begin
            if (nb < W) bits[nb] = sout;
            nb++;
         end
         if (done) begin
            chk("done_busy_low", busy, 0);
            chk("done_with_valid", sout_valid, 1);
            chk("bit_count", nb, W);
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("serial_word", bits, e.r);
               chk("cout", cout, e.c);
               chk("overflow", overflow, e.v);
               chk("latency", cyc - e.st, e.lat);
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
               chk("par_result", result, e.r);
`endif
            end
            nb = 0;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk("idle_timeout", 1, 0);
   endtask

   // Issue one operation; optional stall of nst cycles after bit 3.
   task automatic run_op(input int ua, input int ub, input bit s,
                         input int nst);
      exp_t e;
      wait_idle();
      a = W'(ua); b = W'(ub); sub = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      e = model(ua, ub, s, nst);
      e.st = cyc;
      sb.push_back(e);
      if (nst > 0) begin
         repeat (4) @(posedge clk);
         #1;
         stall = 1'b1;
         for (int i = 0; i < nst; i++) begin
            @(posedge clk); #1;
            chk("stall_valid_low", sout_valid, 0);
            chk("stall_sout_held", sout, e.r[3]);
         end
         stall = 1'b0;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", sout_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_outs", {sout, cout, overflow}, 0);
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
      chk("rst_result", result, 0);
`endif
      reset = 1'b0;

      run_op(100, 27, 0, 0);
      run_op(200, 100, 0, 0);
      run_op(8'h7F, 1, 0, 0);
      run_op(5, 7, 1, 0);
      run_op(8'h80, 1, 1, 0);

      // stalled for three cycles after bit 3
      run_op(100, 27, 0, 3);

      // start during RUN is ignored
      run_op(8'h55, 8'h33, 1, 0);
      @(posedge clk); #1;
      a = 8'hFF; b = 8'hFF; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_ignored", busy, 1);

      // back-to-back: start accepted in the done cycle
      wait_idle();
      chk("in_done_cycle", done, 1);
      run_op(8'hA0, 8'h0F, 0, 0);
      chk("gap_cycle", sout_valid, 0);
      @(posedge clk); #1;
      chk("bit0_after_gap", sout_valid, 1);

      // reset after bit 4 aborts the operation
      run_op(8'h3C, 8'h42, 0, 0);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      void'(sb.pop_back());
      chk("abort_busy", busy, 0);
      chk("abort_valid", sout_valid, 0);
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
      chk("abort_result", result, 0);
`endif
      begin
         int seen = 0;
         for (int i = 0; i < 12; i++) begin
            seen |= int'(done);
            @(posedge clk); #1;
         end
         chk("abort_no_done", seen, 0);
      end
      run_op(8'h3C, 8'h42, 0, 0);

      for (int i = 0; i < 40; i++) begin
         run_op($urandom_range(0, 2**W - 1), $urandom_range(0, 2**W - 1),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end

      begin
         int n = 0;
         while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
         end
         chk("scoreboard_drained", sb.size(), 0);
      end
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor with a start/busy/done handshake. Two WIDTH-bit operands are captured in parallel, then the sum or difference is produced LSB-first, one bit per clock, through a single full adder and a carry flop. Final carry/borrow and signed overflow are flagged with done. It sits between a parallel register file and serial consumers (serial links, bit-serial accumulators) in the arithmetic lab datapath.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; dominates all other inputs
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = a+b, 1 = a−b; sampled with start
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- stall  in  1  freezes a running operation while high
- busy  out  1  operation in progress
- sout  out  1  current result bit (LSB first)
- sout_valid  out  1  sout holds a new bit this cycle
- done  out  1  one-cycle pulse with the last bit
- cout  out  1  final carry out (sub: 1 = no borrow, a ≥ b unsigned); valid while done
- overflow  out  1  signed overflow; valid while done

## Operation
- States: IDLE, RUN. Reset → IDLE; all outputs 0, shift registers, carry, bit counter cleared.
- IDLE & start: load sh_a←a, sh_b←(sub ? ~b : b), carry←sub, cnt←0, busy←1, → RUN. start ignored in RUN.
- RUN & !stall, per edge: s = sh_a[0]^sh_b[0]^carry; sout←s; sout_valid←1; carry←majority(sh_a[0],sh_b[0],carry); shift both right by 1; cnt←cnt+1.
- On the edge where cnt = WIDTH−1: additionally done←1, cout←new carry, overflow←(carry into MSB) ^ (carry out of MSB), busy←0, → IDLE.
- RUN & stall: no state change; sout held, sout_valid←0, done←0.
- Any edge not producing a bit: sout_valid←0, done←0; cout/overflow hold until next done.
- Counter width ⌈log2 WIDTH⌉; all addition modulo 2^WIDTH, no extension.
- Reset mid-operation: aborts, no done, IDLE next cycle.

## Timing
- Edge E0 samples start in IDLE. Edges E1..E_WIDTH (excluding stalled edges) produce bits 0..WIDTH−1; each bit visible in the cycle after its edge.
- busy high from after E0 through after E_WIDTH−1's successor, i.e. low in the cycle done is high.
- done, cout, overflow, last sout all visible together for exactly one cycle.
- start may be asserted in the done cycle (state is IDLE): accepted, next operation's bit 0 follows one cycle after done-cycle + 1. Throughput: one operation per WIDTH+1 cycles, no stalls.
- Stall adds exactly one cycle of latency per stalled RUN cycle.

## Configuration
- SERIAL_ADDSUB_PAR_OUT_EN defined: adds output `result [WIDTH-1:0]`; bits collected MSB-in shift register, full word valid with done and held until next done; reset value 0.
- Not defined: port and collection register absent; serial output only.

## Test plan
- WIDTH=8, a=100, b=27, add: bits 1,1,1,1,1,1,1,0 over 8 valid cycles (127); done on 8th; cout=0, overflow=0; busy low in done cycle.
- a=200, b=100, add: result 0x2C, cout=1, overflow=0; a=0x7F, b=1, add: 0x80, cout=0, overflow=1.
- sub, a=5, b=7: 0xFE, cout=0 (borrow), overflow=0; sub a=0x80, b=1: 0x7F, cout=1, overflow=1.
- Stall held 3 cycles after bit 3: sout_valid low 3 cycles, sout held, done exactly 3 cycles later than unstalled; result unchanged.
- start pulsed with different operands during RUN: ignored, original result intact; start in done cycle: second operation's bit 0 follows with one idle cycle.
- reset asserted after bit 4: next cycle busy=0, sout_valid=0, done never pulses; fresh start afterwards gives correct result (and result=0 after reset with SERIAL_ADDSUB_PAR_OUT_EN).
